// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter
// Shares one MSG_LENGTH-bit transmit channel between NUM_REQ packet sources
// (0 = command responses, 1 = events, 2 = events rate). Round-robin
// arbitration, burst lock while req_last is low, and a watchdog that aborts
// a packet when the transmitter or a bursting requester goes silent.
// Every output comes straight from a flop.

module tx_packet_arbiter #(
    parameter int MSG_LENGTH = 48,
    parameter int NUM_REQ    = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rsnt,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*MSG_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          tx_send,
    output logic [MSG_LENGTH-1:0]         tx_data,
    input  logic                          tx_sent,
    output logic                          timeout_err,
    output logic [7:0]                    timeout_count
);

    // Index width for requester numbers; kept at least one bit wide.
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // The timer only has to reach TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_SENT = 3'd2,
        ACK       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t                  state_q,         state_d;
    logic [IDX_W-1:0]        owner_q,         owner_d;
    logic [IDX_W-1:0]        last_grant_q,    last_grant_d;
    logic                    last_q,          last_d;
    logic [TMR_W-1:0]        timer_q,         timer_d;
    logic [NUM_REQ-1:0]      grant_q,         grant_d;
    logic [NUM_REQ-1:0]      req_ack_q,       req_ack_d;
    logic                    tx_send_q,       tx_send_d;
    logic [MSG_LENGTH-1:0]   tx_data_q,       tx_data_d;
    logic                    timeout_err_q,   timeout_err_d;
    logic [7:0]              timeout_count_q, timeout_count_d;

    // ------------------------------------------------------------------
    // Per-requester view of the flattened data bus
    // ------------------------------------------------------------------
    logic [MSG_LENGTH-1:0] data_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign data_slice[gi] = req_data[gi*MSG_LENGTH +: MSG_LENGTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: search starts one past the previous owner
    // ------------------------------------------------------------------
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] rr_cand;

    // First valid requester in rotated order after last_grant.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!rr_found && req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // One-hot form of the winner.
    logic [NUM_REQ-1:0] rr_onehot;
    assign rr_onehot = NUM_REQ'(1) << rr_idx;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    logic abort;

    // Channel FSM: arbitration, send handshake, burst lock and watchdog.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        last_d          = last_q;
        timer_d         = timer_q;
        grant_d         = grant_q;
        req_ack_d       = '0;
        tx_send_d       = 1'b0;
        tx_data_d       = tx_data_q;
        timeout_err_d   = 1'b0;
        timeout_count_d = timeout_count_q;
        abort           = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = '0;
                if (rr_found) begin
                    // Latch the winner's packet; tx_send rises with SEND.
                    owner_d   = rr_idx;
                    grant_d   = rr_onehot;
                    tx_data_d = data_slice[rr_idx];
                    last_d    = req_last[rr_idx];
                    tx_send_d = 1'b1;
                    timer_d   = '0;
                    state_d   = SEND;
                end
            end

            SEND: begin
                // The timer was zeroed on entry, so it counts cycles since
                // tx_send went high.
                timer_d = timer_q + TMR_W'(1);
                state_d = WAIT_SENT;
            end

            WAIT_SENT: begin
                if (tx_sent) begin
                    req_ack_d = grant_q;
                    state_d   = ACK;
                end else if (timer_q == TMR_LAST) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ACK: begin
                // req_valid is deliberately not looked at here: the
                // requester only sees its ack in this cycle, so its valid
                // still describes the packet just sent.
                if (last_q) begin
                    last_grant_d = owner_q;
                    grant_d      = '0;
                    state_d      = IDLE;
                end else begin
                    timer_d = '0;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                // Burst lock: only the current owner can continue.
                if (req_valid[owner_q]) begin
                    tx_data_d = data_slice[owner_q];
                    last_d    = req_last[owner_q];
                    tx_send_d = 1'b1;
                    timer_d   = '0;
                    state_d   = SEND;
                end else if (timer_q == TMR_LAST) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Shared abort path for a silent transmitter or a stalled burst.
        if (abort) begin
            timeout_err_d = 1'b1;
            if (timeout_count_q != 8'hFF) begin
                timeout_count_d = timeout_count_q + 8'd1;
            end
            last_grant_d = owner_q;
            grant_d      = '0;
            state_d      = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registers with asynchronous active-low reset
    // ------------------------------------------------------------------

    // Control state, watchdog timer and round-robin pointer.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_LAST;
            last_q       <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rsnt) begin
        if (!rsnt) begin
            grant_q         <= '0;
            req_ack_q       <= '0;
            tx_send_q       <= 1'b0;
            tx_data_q       <= '0;
            timeout_err_q   <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            grant_q         <= grant_d;
            req_ack_q       <= req_ack_d;
            tx_send_q       <= tx_send_d;
            tx_data_q       <= tx_data_d;
            timeout_err_q   <= timeout_err_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign grant         = grant_q;
    assign req_ack       = req_ack_q;
    assign tx_send       = tx_send_q;
    assign tx_data       = tx_data_q;
    assign timeout_err   = timeout_err_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Scoreboard bench for tx_packet_arbiter: stimulus pushes expected
// send/ack/timeout events, a negedge monitor pops and compares them.
module tb_tx_packet_arbiter;

    localparam int W        = 48;
    localparam int N        = 3;
    localparam int TMO      = 16;
    localparam int TX_DELAY = 3;

    localparam int K_SEND = 0;
    localparam int K_ACK  = 1;
    localparam int K_TMO  = 2;

    logic             clk;
    logic             rsnt;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ack;
    logic [N-1:0]     grant;
    logic             tx_send;
    logic [W-1:0]     tx_data;
    logic             tx_sent;
    logic             timeout_err;
    logic [7:0]       timeout_count;

    tx_packet_arbiter #(
        .MSG_LENGTH (W),
        .NUM_REQ    (N),
        .TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rsnt          (rsnt),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ack       (req_ack),
        .grant         (grant),
        .tx_send       (tx_send),
        .tx_data       (tx_data),
        .tx_sent       (tx_sent),
        .timeout_err   (timeout_err),
        .timeout_count (timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       last;
    } pkt_t;

    typedef struct {
        int           kind;
        logic [N-1:0] vec;
        logic [W-1:0] data;
    } exp_t;

    pkt_t pkt_q[$];
    exp_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    int drop_total = 0;
    int dropped = 0;
    int stray_req = 0;
    int stray_done = 0;
    int cd = 0;

    int cyc = 0;
    int last_send_cyc = 0;
    int send_cnt = 0;
    int ack_cnt = 0;
    int tmo_since_rst = 0;
    logic [W-1:0] inflight_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic string kind_name(input int k);
        if (k == K_SEND) return "send";
        if (k == K_ACK)  return "ack";
        if (k == K_TMO)  return "timeout";
        return "nothing";
    endfunction

    task automatic order_fail(input string got, input int kind);
        total_cnt++;
        $display("FAIL event_order: got %s, required %s", got, kind_name(kind));
    endtask

    task automatic add_pkt(input int id, input logic [W-1:0] d, input logic l);
        pkt_t p;
        p.id = id; p.data = d; p.last = l;
        pkt_q.push_back(p);
    endtask

    task automatic expect_ev(input int kind, input logic [N-1:0] vec, input logic [W-1:0] d);
        exp_t e;
        e.kind = kind; e.vec = vec; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pkt_q.size() != 0 || grant != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            total_cnt++;
            $display("FAIL wait_%s: got %0d events and %0d packets pending after %0d cycles, required 0",
                     name, exp_q.size(), pkt_q.size(), budget);
            exp_q.delete();
            pkt_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Requesters and transmitter model: drive inputs at the falling edge.
    initial begin
        logic [N-1:0] v;
        logic [N-1:0] l;
        logic [N*W-1:0] d;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_sent   = 1'b0;
        forever begin
            @(negedge clk);
            // Acknowledged packets leave their requester.
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    for (int k = 0; k < pkt_q.size(); k++) begin
                        if (pkt_q[k].id == i) begin
                            pkt_q.delete(k);
                            break;
                        end
                    end
                end
            end
            // Transmitter confirmation, with optional dropped sends.
            tx_sent = 1'b0;
            if (!rsnt) cd = 0;
            if (stray_done != stray_req) begin
                tx_sent = 1'b1;
                stray_done++;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_sent = 1'b1;
            end
            if (tx_send && rsnt) begin
                if (dropped < drop_total) dropped++;
                else cd = TX_DELAY;
            end
            // Present the oldest packet of each requester.
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < pkt_q.size(); k++) begin
                    if (pkt_q[k].id == i) begin
                        v[i] = 1'b1;
                        l[i] = pkt_q[k].last;
                        d[i*W +: W] = pkt_q[k].data;
                        break;
                    end
                end
            end
            req_valid = v;
            req_last  = l;
            req_data  = d;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rsnt) begin
                inflight_data = '0;
                tmo_since_rst = 0;
            end else begin
                if (tx_send) begin
                    send_cnt++;
                    last_send_cyc = cyc;
                    if (exp_q.size() == 0) order_fail("send", -1);
                    else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_SEND) order_fail("send", e.kind);
                        else begin
                            check("send_grant", 64'(grant), 64'(e.vec));
                            check("send_data", 64'(tx_data), 64'(e.data));
                            inflight_data = e.data;
                            $display("send  grant=%b data=%h", grant, tx_data);
                        end
                    end
                end
                if (req_ack != '0) begin
                    ack_cnt++;
                    if (exp_q.size() == 0) order_fail("ack", -1);
                    else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_ACK) order_fail("ack", e.kind);
                        else begin
                            check("ack_vec", 64'(req_ack), 64'(e.vec));
                            $display("ack   req_ack=%b", req_ack);
                        end
                    end
                end
                if (timeout_err) begin
                    tmo_since_rst++;
                    if (exp_q.size() == 0) order_fail("timeout", -1);
                    else begin
                        e = exp_q.pop_front();
                        if (e.kind != K_TMO) order_fail("timeout", e.kind);
                        else begin
                            check("tmo_latency", 64'(cyc - last_send_cyc), 64'(TMO));
                            check("tmo_count", 64'(timeout_count),
                                  64'((tmo_since_rst > 255) ? 255 : tmo_since_rst));
                            check("tmo_grant", 64'(grant), 64'(0));
                            $display("tmo   count=%0d", timeout_count);
                        end
                    end
                end
                check("tx_data_hold", 64'(tx_data), 64'(inflight_data));
            end
        end
    end

    // Directed stimulus.
    initial begin
        int s0;
        int n;
        rsnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_tx_send", 64'(tx_send), 64'(0));
        check("rst_req_ack", 64'(req_ack), 64'(0));
        check("rst_tx_data", 64'(tx_data), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_timeout_count", 64'(timeout_count), 64'(0));
        rsnt = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous requests, all single-packet: order 0,1,2,0.
        add_pkt(0, 48'hA0_0000_0000_00, 1'b1);
        add_pkt(1, 48'hB1_1111_1111_11, 1'b1);
        add_pkt(2, 48'hC2_2222_2222_22, 1'b1);
        add_pkt(0, 48'hA0_0000_0000_01, 1'b1);
        expect_ev(K_SEND, 3'b001, 48'hA0_0000_0000_00); expect_ev(K_ACK, 3'b001, '0);
        expect_ev(K_SEND, 3'b010, 48'hB1_1111_1111_11); expect_ev(K_ACK, 3'b010, '0);
        expect_ev(K_SEND, 3'b100, 48'hC2_2222_2222_22); expect_ev(K_ACK, 3'b100, '0);
        expect_ev(K_SEND, 3'b001, 48'hA0_0000_0000_01); expect_ev(K_ACK, 3'b001, '0);
        wait_done("round_robin", 200);

        // Burst from requester 1 while requester 0 waits.
        add_pkt(1, 48'h0B_0000_0000_B0, 1'b0);
        add_pkt(1, 48'h0B_0000_0000_B1, 1'b1);
        add_pkt(0, 48'h0A_0000_0000_A0, 1'b1);
        expect_ev(K_SEND, 3'b010, 48'h0B_0000_0000_B0); expect_ev(K_ACK, 3'b010, '0);
        expect_ev(K_SEND, 3'b010, 48'h0B_0000_0000_B1); expect_ev(K_ACK, 3'b010, '0);
        expect_ev(K_SEND, 3'b001, 48'h0A_0000_0000_A0); expect_ev(K_ACK, 3'b001, '0);
        wait_done("burst", 200);

        // Transmit timeout on requester 1, then requester 2 is served.
        drop_total += 1;
        add_pkt(1, 48'h77_0000_0000_01, 1'b1);
        add_pkt(2, 48'h77_0000_0000_02, 1'b1);
        expect_ev(K_SEND, 3'b010, 48'h77_0000_0000_01); expect_ev(K_TMO, 3'b000, '0);
        expect_ev(K_SEND, 3'b100, 48'h77_0000_0000_02); expect_ev(K_ACK, 3'b100, '0);
        expect_ev(K_SEND, 3'b010, 48'h77_0000_0000_01); expect_ev(K_ACK, 3'b010, '0);
        wait_done("timeout", 300);
        check("timeout_count_one", 64'(timeout_count), 64'(1));

        // Data stability across a packet, then a stray confirmation in IDLE.
        add_pkt(0, 48'h5A5A_A5A5_5A5A, 1'b1);
        expect_ev(K_SEND, 3'b001, 48'h5A5A_A5A5_5A5A); expect_ev(K_ACK, 3'b001, '0);
        wait_done("stability", 200);
        s0 = ack_cnt;
        n  = send_cnt;
        stray_req++;
        repeat (6) @(posedge clk);
        #1;
        check("stray_no_ack", 64'(ack_cnt), 64'(s0));
        check("stray_no_send", 64'(send_cnt), 64'(n));
        check("stray_grant", 64'(grant), 64'(0));

        // Reset while waiting for tx_sent; pending requester 2 goes first.
        drop_total += 1;
        s0 = send_cnt;
        add_pkt(0, 48'hDEAD_0000_0000, 1'b1);
        expect_ev(K_SEND, 3'b001, 48'hDEAD_0000_0000);
        n = 0;
        while (send_cnt == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_send_seen", 64'(send_cnt != s0), 64'(1));
        add_pkt(2, 48'h2222_0000_BEEF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rsnt = 1'b0;
        #1;
        check("midrst_grant", 64'(grant), 64'(0));
        check("midrst_tx_send", 64'(tx_send), 64'(0));
        check("midrst_req_ack", 64'(req_ack), 64'(0));
        check("midrst_tx_data", 64'(tx_data), 64'(0));
        check("midrst_timeout_err", 64'(timeout_err), 64'(0));
        check("midrst_timeout_count", 64'(timeout_count), 64'(0));
        for (int k = pkt_q.size() - 1; k >= 0; k--) begin
            if (pkt_q[k].id == 0) pkt_q.delete(k);
        end
        expect_ev(K_SEND, 3'b100, 48'h2222_0000_BEEF); expect_ev(K_ACK, 3'b100, '0);
        repeat (2) @(posedge clk);
        #1;
        rsnt = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_first_send", 64'(tx_send), 64'(1));
        check("post_rst_first_grant", 64'(grant), 64'(3'b100));
        wait_done("reset", 200);

        // 300 forced timeouts: counter saturates at 255.
        drop_total += 300;
        add_pkt(0, 48'h5A7_0000_0000, 1'b1);
        for (int i = 0; i < 300; i++) begin
            expect_ev(K_SEND, 3'b001, 48'h5A7_0000_0000);
            expect_ev(K_TMO, 3'b000, '0);
        end
        expect_ev(K_SEND, 3'b001, 48'h5A7_0000_0000); expect_ev(K_ACK, 3'b001, '0);
        wait_done("saturation", 7000);
        check("timeout_count_sat", 64'(timeout_count), 64'(255));

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
